// File: rtl/approx_error_monitor.sv
// Error-statistics monitor for the approximate multiplier: accepts exact/approx
// product pairs over a programmed run and accumulates count, errored count,
// saturating |error| sum and maximum |error|. Two-stage pipeline (diff, stats).
module approx_error_monitor #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] sample_target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   exact_prod,
    input  logic [2*N-1:0]   approx_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] err_sum,
    output logic [2*N-1:0]   err_max
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             done_next;
    logic             clear;
    logic             accept;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] acc_cnt;

    logic             s1_valid;
    logic [2*N-1:0]   s1_diff;
    logic [2*N-1:0]   diff;
    logic [ACC_W:0]   sum_ext;

    assign in_ready = (state == RUN) && (acc_cnt < target);
    assign busy     = (state == RUN);
    assign accept   = in_valid && in_ready;

    // Unsigned absolute difference: larger minus smaller, never negative.
    assign diff = (exact_prod >= approx_prod) ? (exact_prod - approx_prod)
                                              : (approx_prod - exact_prod);

    // One extra bit catches the carry that signals saturation.
    assign sum_ext = {1'b0, err_sum} + {{(ACC_W + 1 - 2*N){1'b0}}, s1_diff};

    // Next-state, run-start clear and done-pulse decode.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear = 1'b1;
                    if (sample_target == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if ((acc_cnt == target) && !s1_valid) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: state, latched target, accept counter, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            target  <= '0;
            acc_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (clear) begin
                target  <= sample_target;
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: register absolute difference of the accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= diff;
            end
        end
    end

    // Stage 2: fold the registered difference into the run statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            err_count    <= '0;
            err_sum      <= '0;
            err_max      <= '0;
        end else if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
            err_sum      <= '0;
            err_max      <= '0;
        end else if (s1_valid) begin
            sample_count <= sample_count + CNT_W'(1);
            if (s1_diff != '0) begin
                err_count <= err_count + CNT_W'(1);
            end
            err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (s1_diff > err_max) begin
                err_max <= s1_diff;
            end
        end
    end

endmodule
